// File: rtl/lot_pkg.sv
// lot_pkg: shared state encoding, prize table and digit helpers for the lottery round controller.
package lot_pkg;

  typedef enum logic [2:0] {
    COLLECT,
    DRAW,
    CHECK,
    PAY,
    SHOW
  } state_t;

  localparam int unsigned BET_W    = 16;
  localparam logic [3:0]  PRIZE_M4 = 4'd9;
  localparam logic [3:0]  PRIZE_M3 = 4'd5;
  localparam logic [3:0]  PRIZE_M2 = 4'd1;
  localparam int unsigned BCD_MAX  = 99;

  function automatic logic [3:0] prize_of(input logic [2:0] m);
    case (m)
      3'd4:    return PRIZE_M4;
      3'd3:    return PRIZE_M3;
      3'd2:    return PRIZE_M2;
      default: return 4'd0;
    endcase
  endfunction

  // Folds a 4-bit LFSR nibble onto 0..9.
  function automatic logic [3:0] lfsr_digit(input logic [3:0] l);
    return (l < 4'd10) ? l : l - 4'd10;
  endfunction

endpackage

// File: rtl/lot_lfsr16.sv
// lot_lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded on reset.
module lot_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [3:0] o_nib
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_lfsr <= SEED;
    else       r_lfsr <= {r_lfsr[14:0], w_fb};
  end

  assign o_nib = r_lfsr[3:0];

endmodule

// File: rtl/loteria_round_ctrl.sv
// loteria_round_ctrl: buffers bets, draws 4 digits, scores bets and keeps a saturating BCD total.
// Define LOT_EDGE_DETECT_EN to treat insert/finish as level keys with registered rising-edge detect.
module loteria_round_ctrl
  import lot_pkg::*;
#(
  parameter int unsigned N_BETS    = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] num0,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [3:0] num3,
  input  logic       insert,
  input  logic       finish,
  output logic [3:0] draw0,
  output logic [3:0] draw1,
  output logic [3:0] draw2,
  output logic [3:0] draw3,
  output logic       win,
  output logic [3:0] p0,
  output logic [3:0] p1,
  output logic [3:0] p2,
  output logic [2:0] bet_cnt,
  output logic       busy
);

  state_t                  r_state, w_next;
  logic [N_BETS*BET_W-1:0] r_bets;
  logic [3:0]              r_draw [4];
  logic [2:0]              r_bet_cnt, r_idx;
  logic [3:0]              r_max, r_p0, r_p1, r_p2;
  logic                    r_win;
  logic                    w_ins_ev, w_fin_ev, w_digits_ok, w_store, w_carry;
  logic [3:0]              w_nib, w_digit, w_prize, w_p1_nxt, w_p2_nxt;
  logic [BET_W-1:0]        w_bet, w_cur;
  logic [2:0]              w_match;
  logic [4:0]              w_units, w_tens;

`ifdef LOT_EDGE_DETECT_EN
  logic r_ins_q, r_fin_q, r_ins_ev, r_fin_ev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ins_q  <= 1'b0;
      r_fin_q  <= 1'b0;
      r_ins_ev <= 1'b0;
      r_fin_ev <= 1'b0;
    end else begin
      r_ins_q  <= insert;
      r_fin_q  <= finish;
      r_ins_ev <= insert & ~r_ins_q;
      r_fin_ev <= finish & ~r_fin_q;
    end
  end

  assign w_ins_ev = r_ins_ev;
  assign w_fin_ev = r_fin_ev;
`else
  assign w_ins_ev = insert;
  assign w_fin_ev = finish;
`endif

  lot_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk (clk),
    .i_rst (reset),
    .o_nib (w_nib)
  );

  assign w_digit     = lfsr_digit(w_nib);
  assign w_bet       = {num0, num1, num2, num3};
  assign w_digits_ok = (num0 <= 4'd9) && (num1 <= 4'd9) && (num2 <= 4'd9) && (num3 <= 4'd9);
  assign w_store     = (r_state == COLLECT) && w_ins_ev && w_digits_ok
                       && (r_bet_cnt != 3'(N_BETS));

  assign w_cur   = r_bets[r_idx*BET_W +: BET_W];
  assign w_match = 3'(w_cur[15:12] == r_draw[0]) + 3'(w_cur[11:8] == r_draw[1])
                 + 3'(w_cur[7:4]   == r_draw[2]) + 3'(w_cur[3:0]  == r_draw[3]);
  assign w_prize = prize_of(w_match);

  // Digit-wise BCD add of the round prize into the total, clamped at 99.
  always_comb begin
    w_units  = {1'b0, r_p2} + {1'b0, r_max};
    w_carry  = (w_units > 5'd9);
    w_p2_nxt = w_carry ? 4'(w_units - 5'd10) : w_units[3:0];
    w_tens   = {1'b0, r_p1} + {4'b0, w_carry};
    w_p1_nxt = w_tens[3:0];
    if (w_tens > 5'd9) begin
      w_p1_nxt = 4'(BCD_MAX / 10);
      w_p2_nxt = 4'(BCD_MAX % 10);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= COLLECT;
    else       r_state <= w_next;
  end

  // An insert event always wins over a simultaneous finish in COLLECT.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    case (r_state)
      COLLECT: if (!w_ins_ev && w_fin_ev && (r_bet_cnt != '0)) w_next = DRAW;
      DRAW: begin
        busy = 1'b1;
        if (r_idx == 3'd3) w_next = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (r_idx == r_bet_cnt - 3'd1) w_next = PAY;
      end
      PAY: begin
        busy   = 1'b1;
        w_next = SHOW;
      end
      SHOW:    if (w_ins_ev || w_fin_ev) w_next = COLLECT;
      default: w_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bets    <= '0;
      r_bet_cnt <= '0;
      r_idx     <= '0;
      r_max     <= '0;
      r_p0      <= '0;
      r_p1      <= '0;
      r_p2      <= '0;
      r_win     <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) r_draw[k] <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          r_idx <= '0;
          r_max <= '0;
          if (w_store) begin
            r_bets[r_bet_cnt*BET_W +: BET_W] <= w_bet;
            r_bet_cnt                        <= r_bet_cnt + 3'd1;
          end
        end
        DRAW: begin
          r_draw[r_idx[1:0]] <= w_digit;
          r_idx              <= (r_idx == 3'd3) ? '0 : r_idx + 3'd1;
        end
        CHECK: begin
          if (w_prize > r_max) r_max <= w_prize;
          r_idx <= r_idx + 3'd1;
        end
        PAY: begin
          r_p0  <= r_max;
          r_win <= (r_max != '0);
          r_p1  <= w_p1_nxt;
          r_p2  <= w_p2_nxt;
        end
        SHOW: begin
          if (w_ins_ev || w_fin_ev) begin
            r_bet_cnt <= '0;
            r_p0      <= '0;
            r_win     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign draw0   = r_draw[0];
  assign draw1   = r_draw[1];
  assign draw2   = r_draw[2];
  assign draw3   = r_draw[3];
  assign win     = r_win;
  assign p0      = r_p0;
  assign p1      = r_p1;
  assign p2      = r_p2;
  assign bet_cnt = r_bet_cnt;

endmodule
